median_frame_sequencer: RTL and testbench
=========================================

Name: median_frame_sequencer

Overview:
- Scans one frame stored column-major in a source pixel memory, pixel index p = c*ROW + r.
- For each pixel it fetches the 3x3 neighbourhood and presents it, with the pixel index, to the 3x3 median filter datapath. It then writes the filtered byte to a result memory at address p.
- The filter itself handles border replication; this block only fetches in-range addresses, sequences the filter and reports frame completion.

Parameters:
- ROW, 430, pixels per column (vertical size; r ranges 0..ROW-1).
- COL, 554, number of columns (c ranges 0..COL-1).
- AW, 18, memory address width; must satisfy 2^AW >= ROW*COL.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock; reset is synchronous and active-low.
- start  in  1  one-cycle pulse begins a frame; ignored unless idle.
- busy  out  1  high from the cycle after an accepted start until frame_done.
- frame_done  out  1  one-cycle pulse after the last write.
- rd_addr  out  AW  source memory read address; synchronous read, data valid next cycle.
- rd_data  in  8  source memory read data.
- pixel  out  32 signed  current pixel index p, to the filter pixel input.
- win_0..win_8  out  8 each  window to filter data_in_0..8; k = 3*dr + dc samples (r-1+dr, c-1+dc).
- filt_data  in  8  filter output, registered one clock after window/pixel are sampled.
- wr_en  out  1  result write strobe.
- wr_addr  out  AW  result address, equal to p.
- wr_data  out  8  result byte.

Behaviour:
- Reset (rst_n=0 at an edge): state IDLE; r=c=k=0.
  - busy, frame_done, wr_en = 0; rd_addr, wr_addr, wr_data, pixel, win_0..8 = 0.
  - Reset mid-frame aborts immediately with no further writes.
- Index tracking: r and c counters, no division or modulo.
  - p advances by 1; r wraps ROW-1 -> 0 with c incrementing.
  - pixel = c*ROW + r, maintained incrementally.
- FSM states: IDLE, FETCH, SETTLE, FILT, WRITE, DONE.
- IDLE: on start, go to FETCH with r=c=k=0 and busy=1.
- FETCH: 9 cycles, k = 0..8, with rd_addr = clamp(c-1+dc)*ROW + clamp(r-1+dr).
  - Each coordinate is clamped to its valid range; clamped values are don't-care to the filter but must be legal addresses.
  - rd_data arriving in the cycle after issue k is latched into win_k.
  - After k=8, go to SETTLE.
- SETTLE: 1 cycle; latches win_8.
- FILT: 1 cycle; win_0..8 and pixel are held stable, and the filter samples them at the closing edge.
- WRITE: 1 cycle; wr_en=1, wr_addr=p, wr_data=filt_data.
  - If p = ROW*COL-1, go to DONE; otherwise advance p, set k=0 and go to FETCH.
- DONE: 1 cycle; frame_done=1, busy=0 after it; return to IDLE.
- Throughput: fixed 12 cycles per pixel. Frame = 12*ROW*COL cycles from the first FETCH to the final WRITE.
- pixel and win_* change only in FETCH and SETTLE; they are stable throughout FILT.
- start while busy or in DONE is ignored.
- start coincident with rst_n=0: reset wins.
- wr_en is never high outside WRITE. Exactly ROW*COL writes occur per frame, in ascending address order.

Decomposition:
- Shared package holds:
  - FSM state enumeration.
  - Fetch-offset tables dr[k] = k/3 and dc[k] = k%3 as constants.
  - Cycles-per-pixel constant 12.
- One natural sub-module, median_addr_gen: combinational clamped address from (r, c, k, ROW, COL).

Test Plan:
- Reset, ROW=4 COL=3: assert rst_n=0 for 2 cycles -> all outputs 0, busy=0; start pulse then reset at cycle 20 -> no wr_en afterwards, busy=0.
- Constant image 0x55, ROW=4 COL=3, reference filter attached:
  - 12 writes, addresses 0..11, all data 0x55.
  - Writes 12 cycles apart; frame_done pulses once, the cycle after the write to address 11; busy high for 144+1 cycles.
- Interior fetch, ROW=4 COL=3, pixel 5 -> rd_addr sequence 0,4,8,1,5,9,2,6,10.
- Corner fetch, pixel 0 -> rd_addr sequence 0,0,4,0,0,4,1,1,5, all in range; pixel 11 -> all addresses <= 11.
- Impulse: zero image except addr 5 = 0xFF, real median filter attached -> all 12 written bytes 0x00.
- Start while busy at cycle 30 -> ignored, write count still 12.
- Restart after DONE -> second frame identical to the first.

Source files
------------

// File: rtl/median_frame_sequencer_pkg.sv
// Shared constants for the median frame sequencer: FSM encoding, 3x3 fetch
// offset tables and the fixed per-pixel cycle budget.
package median_frame_sequencer_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_FILT   = 3'd3;
    localparam logic [2:0] S_WRITE  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam int CYC_PER_PIX = 12;

    // Element k holds k/3 (row offset) and k%3 (column offset).
    localparam logic [8:0][1:0] DR_TAB = {2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0};
    localparam logic [8:0][1:0] DC_TAB = {2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0};

endpackage

// File: rtl/median_frame_sequencer_if.sv
// Memory and filter side bus of the median frame sequencer.
interface median_frame_sequencer_if #(
    parameter int AW = 18
);
    logic [AW-1:0]      rd_addr;
    logic [7:0]         rd_data;
    logic signed [31:0] pixel;
    logic [7:0]         win_0, win_1, win_2, win_3, win_4, win_5, win_6, win_7, win_8;
    logic [7:0]         filt_data;
    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic [7:0]         wr_data;

    modport master (
        output rd_addr, input rd_data, output pixel,
        output win_0, win_1, win_2, win_3, win_4, win_5, win_6, win_7, win_8,
        input  filt_data, output wr_en, wr_addr, wr_data
    );

    modport slave (
        input  rd_addr, output rd_data, input pixel,
        input  win_0, win_1, win_2, win_3, win_4, win_5, win_6, win_7, win_8,
        output filt_data, input wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/median_frame_sequencer_addr_gen.sv
// Clamped source address for neighbourhood sample k of pixel (r, c).
module median_addr_gen
    import median_frame_sequencer_pkg::*;
#(
    parameter int ROW = 430,
    parameter int COL = 554,
    parameter int AW  = 18,
    parameter int RW  = $clog2(ROW + 1),
    parameter int CW  = $clog2(COL + 1)
) (
    input  logic [RW-1:0] i_r,
    input  logic [CW-1:0] i_c,
    input  logic [3:0]    i_k,
    output logic [AW-1:0] o_addr
);
    localparam logic [RW-1:0] R_ONE  = RW'(1);
    localparam logic [CW-1:0] C_ONE  = CW'(1);
    localparam logic [RW-1:0] R_LAST = RW'(ROW - 1);
    localparam logic [CW-1:0] C_LAST = CW'(COL - 1);

    logic [1:0]    w_dr, w_dc;
    logic [RW-1:0] w_rr;
    logic [CW-1:0] w_cc;

    // Offsets of 0 and 2 step one sample out; clamping keeps the address legal.
    always_comb begin
        w_dr = (i_k <= 4'd8) ? DR_TAB[i_k] : 2'd1;
        w_dc = (i_k <= 4'd8) ? DC_TAB[i_k] : 2'd1;

        w_rr = i_r;
        if (w_dr == 2'd0 && i_r != '0)          w_rr = i_r - R_ONE;
        else if (w_dr == 2'd2 && i_r != R_LAST) w_rr = i_r + R_ONE;

        w_cc = i_c;
        if (w_dc == 2'd0 && i_c != '0)          w_cc = i_c - C_ONE;
        else if (w_dc == 2'd2 && i_c != C_LAST) w_cc = i_c + C_ONE;
    end

    assign o_addr = AW'(w_cc) * AW'(ROW) + AW'(w_rr);

endmodule

// File: rtl/median_frame_sequencer.sv
// Walks a column-major frame, fetches each 3x3 neighbourhood, drives the
// median filter and writes the filtered byte back at the pixel address.
module median_frame_sequencer
    import median_frame_sequencer_pkg::*;
#(
    parameter int ROW = 430,
    parameter int COL = 554,
    parameter int AW  = 18
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic busy,
    output logic frame_done,
    median_frame_sequencer_if.master bus
);
    localparam int            RW     = $clog2(ROW + 1);
    localparam int            CW     = $clog2(COL + 1);
    localparam logic [3:0]    K_LAST = 4'(CYC_PER_PIX - 4);
    localparam logic [AW-1:0] P_LAST = AW'(ROW * COL - 1);
    localparam logic [RW-1:0] R_LAST = RW'(ROW - 1);

    logic [2:0]    r_state;
    logic [RW-1:0] r_r;
    logic [CW-1:0] r_c;
    logic [3:0]    r_k;
    logic [AW-1:0] r_p;
    logic [7:0]    r_win [0:8];

    logic [AW-1:0] w_addr;
    logic [3:0]    w_kprev;
    logic          w_wr;

    median_addr_gen #(
        .ROW(ROW), .COL(COL), .AW(AW), .RW(RW), .CW(CW)
    ) u_addr_gen (
        .i_r(r_r), .i_c(r_c), .i_k(r_k), .o_addr(w_addr)
    );

    assign w_kprev = r_k - 4'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_r     <= '0;
            r_c     <= '0;
            r_k     <= '0;
            r_p     <= '0;
            for (int i = 0; i < 9; i++) r_win[i] <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_FETCH;
                        r_r     <= '0;
                        r_c     <= '0;
                        r_k     <= '0;
                        r_p     <= '0;
                    end
                end
                S_FETCH: begin
                    // Read data lags its address by one cycle, so this lands sample k-1.
                    if (r_k != 4'd0) r_win[w_kprev] <= bus.rd_data;
                    if (r_k == K_LAST) r_state <= S_SETTLE;
                    else               r_k     <= r_k + 4'd1;
                end
                S_SETTLE: begin
                    r_win[8] <= bus.rd_data;
                    r_state  <= S_FILT;
                end
                S_FILT: r_state <= S_WRITE;
                S_WRITE: begin
                    if (r_p == P_LAST) begin
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_FETCH;
                        r_k     <= '0;
                        r_p     <= r_p + AW'(1);
                        if (r_r == R_LAST) begin
                            r_r <= '0;
                            r_c <= r_c + CW'(1);
                        end else begin
                            r_r <= r_r + RW'(1);
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_wr       = (r_state == S_WRITE);
    assign busy       = (r_state != S_IDLE);
    assign frame_done = (r_state == S_DONE);

    assign bus.rd_addr = (r_state == S_FETCH) ? w_addr : '0;
    assign bus.pixel   = signed'(32'(r_p));
    assign bus.wr_en   = w_wr;
    assign bus.wr_addr = r_p;
    assign bus.wr_data = w_wr ? bus.filt_data : 8'd0;

    assign bus.win_0 = r_win[0];
    assign bus.win_1 = r_win[1];
    assign bus.win_2 = r_win[2];
    assign bus.win_3 = r_win[3];
    assign bus.win_4 = r_win[4];
    assign bus.win_5 = r_win[5];
    assign bus.win_6 = r_win[6];
    assign bus.win_7 = r_win[7];
    assign bus.win_8 = r_win[8];

endmodule

// File: tb/tb_median_frame_sequencer.sv
// Self-checking bench: 4x3 frame, source memory and median filter models,
// write scoreboard, fetch-address log and timing checks.
module tb_median_frame_sequencer;
    localparam int ROW  = 4;
    localparam int COL  = 3;
    localparam int AW   = 8;
    localparam int NPIX = ROW * COL;

    typedef struct {
        int         addr;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy, frame_done;

    median_frame_sequencer_if #(.AW(AW)) u_if();

    median_frame_sequencer #(.ROW(ROW), .COL(COL), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .busy(busy), .frame_done(frame_done), .bus(u_if)
    );

    always #5 clk = ~clk;

    logic [7:0] img [NPIX];
    exp_t       sb [$];
    int         n_assert = 0;
    int         n_fail   = 0;
    int         rd_log [200];
    int         fc = 0, wr_cnt = 0, oob = 0, busy_cyc = 0, done_cnt = 0;
    bit         mon_en = 0;
    exp_t       e_mon;
    logic [7:0] fw [9];

    function automatic logic [7:0] med9(input logic [7:0] v [9]);
        logic [7:0] s [9];
        logic [7:0] t;
        s = v;
        for (int i = 0; i < 9; i++)
            for (int j = 0; j < 8 - i; j++)
                if (s[j] > s[j+1]) begin t = s[j]; s[j] = s[j+1]; s[j+1] = t; end
        return s[4];
    endfunction

    function automatic logic [7:0] ref_px(input int p);
        logic [7:0] v [9];
        int r, c, rr, cc;
        r = p % ROW;
        c = p / ROW;
        for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++) begin
                rr = r - 1 + dr; if (rr < 0) rr = 0; if (rr > ROW - 1) rr = ROW - 1;
                cc = c - 1 + dc; if (cc < 0) cc = 0; if (cc > COL - 1) cc = COL - 1;
                v[3*dr + dc] = img[cc*ROW + rr];
            end
        return med9(v);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input int p);
        exp_t e;
        e.addr = p;
        e.data = ref_px(p);
        sb.push_back(e);
    endtask

    // Source memory: synchronous read, poison value for illegal addresses.
    always @(posedge clk)
        u_if.rd_data <= (int'(u_if.rd_addr) < NPIX) ? img[u_if.rd_addr[3:0]] : 8'hEE;

    always_comb begin
        fw[0] = u_if.win_0; fw[1] = u_if.win_1; fw[2] = u_if.win_2;
        fw[3] = u_if.win_3; fw[4] = u_if.win_4; fw[5] = u_if.win_5;
        fw[6] = u_if.win_6; fw[7] = u_if.win_7; fw[8] = u_if.win_8;
    end

    always @(posedge clk) u_if.filt_data <= med9(fw);

    always @(negedge clk) begin
        if (mon_en) begin
            if (busy) begin
                if (fc < 200) rd_log[fc] = int'(u_if.rd_addr);
                if (int'(u_if.rd_addr) >= NPIX) oob++;
                busy_cyc++;
            end
            if (frame_done) done_cnt++;
            if (u_if.wr_en) begin
                wr_cnt++;
                chk("write_expected", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    e_mon = sb.pop_front();
                    chk("wr_addr", 32'(u_if.wr_addr), e_mon.addr);
                    chk("wr_data", 32'(u_if.wr_data), 32'(e_mon.data));
                    chk("wr_slot", fc, e_mon.addr * 12 + 11);
                end
            end
            fc = busy ? fc + 1 : 0;
        end
    end

    task automatic run_frame(input string tag, input int extra_at);
        int  w0, d0, i;
        bit  seen;
        for (int p = 0; p < NPIX; p++) push_exp(p);
        w0 = wr_cnt; d0 = done_cnt; busy_cyc = 0; oob = 0; seen = 0;
        start = 1'b1;
        for (i = 1; i <= 400; i++) begin
            @(negedge clk);
            start = (i == extra_at);
            if (frame_done) begin seen = 1; break; end
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        chk({tag, "_done_cycle"}, i, 145);
        @(negedge clk); #1;
        chk({tag, "_busy_low"}, 32'(busy), 32'd0);
        chk({tag, "_busy_cycles"}, busy_cyc, 145);
        chk({tag, "_done_pulses"}, done_cnt - d0, 1);
        chk({tag, "_writes"}, wr_cnt - w0, NPIX);
        chk({tag, "_sb_empty"}, sb.size(), 0);
        chk({tag, "_rd_in_range"}, oob, 0);
        repeat (20) @(negedge clk); #1;
        chk({tag, "_no_extra_writes"}, wr_cnt - w0, NPIX);
        chk({tag, "_no_extra_done"}, done_cnt - d0, 1);
    endtask

    initial begin
        int exp5 [9];
        int exp0 [9];
        int w0;
        exp5 = '{0, 4, 8, 1, 5, 9, 2, 6, 10};
        exp0 = '{0, 0, 4, 0, 0, 4, 1, 1, 5};
        for (int i = 0; i < NPIX; i++) img[i] = 8'h55;

        // Reset held for two edges with start asserted alongside it.
        rst_n = 1'b0; start = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_wr_en", 32'(u_if.wr_en), 0);
        chk("rst_rd_addr", 32'(u_if.rd_addr), 0);
        chk("rst_wr_addr", 32'(u_if.wr_addr), 0);
        chk("rst_wr_data", 32'(u_if.wr_data), 0);
        chk("rst_pixel", u_if.pixel, 0);
        chk("rst_win_0", 32'(u_if.win_0), 0);
        chk("rst_win_8", 32'(u_if.win_8), 0);
        rst_n = 1'b1; start = 1'b0;
        @(negedge clk); #1;
        chk("start_in_reset_ignored", 32'(busy), 0);
        mon_en = 1;

        // Abort a frame by reset during frame cycle 20: only pixel 0 is written.
        push_exp(0);
        w0 = wr_cnt;
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        repeat (40) @(negedge clk); #1;
        chk("abort_writes", wr_cnt - w0, 1);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_sb_empty", sb.size(), 0);

        run_frame("const", 0);
        for (int k = 0; k < 9; k++) chk("fetch_pix5", rd_log[5*12 + k], exp5[k]);
        for (int k = 0; k < 9; k++) chk("fetch_pix0", rd_log[k], exp0[k]);
        for (int k = 0; k < 9; k++) chk("fetch_pix11_le11", 32'(rd_log[11*12 + k] <= 11), 1);

        for (int i = 0; i < NPIX; i++) img[i] = 8'h00;
        img[5] = 8'hFF;
        run_frame("impulse", 30);
        run_frame("restart", 0);

        for (int i = 0; i < NPIX; i++) img[i] = 8'($urandom_range(0, 255));
        run_frame("random", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
